mips_mc_controller: RTL and testbench

//  Multicycle MIPS control FSM, next generation of the core's controller. Drives every datapath

---
 rtl/mips_ctrl_pkg.sv | 77 +++++++
 rtl/mips_alu_decoder.sv | 32 +++
 rtl/mips_mc_controller.sv | 194 +++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes, functs and encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_JAL,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_DATA   = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_e s);
    case (s)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps ALU operation class and R-type funct to an ALU control code
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_e     alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with memory wait states, trap and retire counter
// MIPS_CTRL_JAL_EN enables the jal instruction; without it opcode 0x03 traps.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          OpCode,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                BranchNe,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALU_OP_W-1:0] ALUControl,
  output logic                PCEn,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  aluop_e           alu_op;
  logic [3:0]       alu_ctrl;
  logic             funct_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    alu_op = ALUOP_ADD;
    case (state_q)
      S_BRANCH: alu_op = ALUOP_SUB;
      S_EXEC:   alu_op = ALUOP_FUNCT;
      default:  alu_op = ALUOP_ADD;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .alu_op_i        (alu_op),
    .funct_i         (Funct),
    .alu_ctrl_o      (alu_ctrl),
    .funct_illegal_o (funct_illegal)
  );

  // Reset gates every output so nothing is strobed in the reset cycle, even mid-access.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    ALUSrcA  = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    RegDst   = DST_RT;
    MemtoReg = WB_ALUOUT;
    ALUSrcB  = SRCB_REG;
    PCSrc    = PC_ALU;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH;
          case (OpCode)
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_RTYPE:       state_d = S_EXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_ADDI:        state_d = S_ADDIEX;
            OP_J:           state_d = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
            OP_JAL:         state_d = S_JAL;
`else
            OP_JAL:         state_d = S_TRAP;
`endif
            default:        state_d = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegDst   = DST_RT;
          MemtoReg = WB_DATA;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REG;
          state_d = funct_illegal ? S_TRAP : S_ALUWB;
        end
        S_ALUWB: begin
          RegDst   = DST_RD;
          MemtoReg = WB_ALUOUT;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_REG;
          PCSrc    = PC_ALUOUT;
          Branch   = (OpCode == OP_BEQ);
          BranchNe = (OpCode == OP_BNE);
          state_d  = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegDst   = DST_RT;
          MemtoReg = WB_ALUOUT;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_JUMP: begin
          PCSrc   = PC_JUMP;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end
`ifdef MIPS_CTRL_JAL_EN
        S_JAL: begin
          RegDst   = DST_RA;
          MemtoReg = WB_PC;
          RegWrite = 1'b1;
          PCSrc    = PC_JUMP;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end
`else
        S_JAL:   state_d = S_TRAP;
`endif
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_TRAP;
      endcase
    end
  end

  assign illegal_d   = illegal_q | (state_d == S_TRAP);
  assign cnt_d       = (is_retire_state(state_q) && (state_d == S_FETCH)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign ALUControl  = rst ? '0 : ALU_OP_W'(alu_ctrl);
  assign PCEn        = PCWrite | (Branch & Zero) | (BranchNe & ~Zero);
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed scoreboard bench for the multicycle MIPS controller
module tb_mips_mc_controller;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  OpCode = 6'h00;
  logic [5:0]  Funct = 6'h00;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemWrite, IorD, IRWrite, ALUSrcA, RegWrite, PCWrite, Branch, BranchNe;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic [3:0]  ALUControl;
  logic        PCEn, illegal;
  logic [31:0] instr_count;

  mips_mc_controller #(.ALU_OP_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .PCEn(PCEn), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, MemWrite, IorD, IRWrite, ALUSrcA, RegWrite, PCWrite, Branch, BranchNe, PCEn, illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
    logic [3:0] ALUControl;
  } outs_t;

  outs_t obs;
  assign obs = {mem_req, MemWrite, IorD, IRWrite, ALUSrcA, RegWrite, PCWrite, Branch, BranchNe,
                PCEn, illegal, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUControl};

  outs_t       e, m;
  outs_t       exp_q[$];
  outs_t       msk_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = '0;

  // Strobes and the trap flag are always defined; selects only where the state gives them meaning.
  task automatic base(input logic ill);
    e = '0;
    m = '0;
    m.mem_req = 1'b1; m.MemWrite = 1'b1; m.IRWrite = 1'b1; m.RegWrite = 1'b1; m.PCWrite = 1'b1;
    m.Branch = 1'b1; m.BranchNe = 1'b1; m.PCEn = 1'b1; m.illegal = 1'b1;
    e.illegal = ill;
  endtask

  task automatic sa(input logic v);         e.ALUSrcA = v;    m.ALUSrcA = 1'b1;  endtask
  task automatic sb(input logic [1:0] v);   e.ALUSrcB = v;    m.ALUSrcB = '1;    endtask
  task automatic alu(input logic [3:0] v);  e.ALUControl = v; m.ALUControl = '1; endtask
  task automatic pcs(input logic [1:0] v);  e.PCSrc = v;      m.PCSrc = '1;      endtask
  task automatic iord(input logic v);       e.IorD = v;       m.IorD = 1'b1;     endtask
  task automatic rdst(input logic [1:0] v); e.RegDst = v;     m.RegDst = '1;     endtask
  task automatic m2r(input logic [1:0] v);  e.MemtoReg = v;   m.MemtoReg = '1;   endtask

  task automatic settle_check(input string tag, input bit chk_cnt);
    outs_t ex, mk;
    string t;
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(tag);
    #1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      mk = msk_q.pop_front();
      t  = tag_q.pop_front();
      checks++;
      assert ((obs & mk) === (ex & mk)) else begin
        failures++;
        $error("FAIL %s: outputs=%h expected=%h (mask %h)", t, obs & mk, ex & mk, mk);
      end
    end
    if (chk_cnt) begin
      checks++;
      assert (instr_count === exp_cnt) else begin
        failures++;
        $error("FAIL %s_count: instr_count=%0d expected=%0d", tag, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic step(input string tag);
    settle_check(tag, 1'b1);
    @(negedge clk);
  endtask

  task automatic rnd_in();
    mem_ready = 1'($urandom_range(0, 1));
    Zero      = 1'($urandom_range(0, 1));
  endtask

  task automatic ph_fetch(input logic rdy);
    mem_ready = rdy; Zero = 1'($urandom_range(0, 1));
    base(1'b0); iord(1'b0); sa(1'b0); sb(2'd1); alu(ALU_ADD); pcs(2'd0);
    e.mem_req = 1'b1; e.IRWrite = rdy; e.PCWrite = rdy; e.PCEn = rdy;
    step("fetch");
  endtask

  task automatic ph_decode();
    rnd_in(); base(1'b0); sa(1'b0); sb(2'd3); alu(ALU_ADD);
    step("decode");
  endtask

  task automatic ph_memadr();
    rnd_in(); base(1'b0); sa(1'b1); sb(2'd2); alu(ALU_ADD);
    step("memadr");
  endtask

  task automatic ph_memrd(input logic rdy);
    mem_ready = rdy; base(1'b0); e.mem_req = 1'b1; iord(1'b1);
    step("memrd");
  endtask

  task automatic ph_memwb();
    rnd_in(); base(1'b0); rdst(2'd0); m2r(2'd1); e.RegWrite = 1'b1;
    step("memwb");
  endtask

  task automatic ph_memwr(input logic rdy);
    mem_ready = rdy; base(1'b0); e.mem_req = 1'b1; e.MemWrite = 1'b1; iord(1'b1);
    step("memwr");
  endtask

  task automatic ph_exec(input logic [3:0] code, input bit known);
    rnd_in(); base(1'b0); sa(1'b1); sb(2'd0);
    if (known) alu(code);
    step("exec");
  endtask

  task automatic ph_aluwb();
    rnd_in(); base(1'b0); rdst(2'd1); m2r(2'd0); e.RegWrite = 1'b1;
    step("aluwb");
  endtask

  task automatic ph_branch(input logic beq, input logic z);
    mem_ready = 1'($urandom_range(0, 1)); Zero = z;
    base(1'b0); sa(1'b1); sb(2'd0); alu(ALU_SUB); pcs(2'd1);
    e.Branch = beq; e.BranchNe = ~beq; e.PCEn = beq ? z : ~z;
    step(beq ? "beq" : "bne");
  endtask

  task automatic ph_addiex();
    rnd_in(); base(1'b0); sa(1'b1); sb(2'd2); alu(ALU_ADD);
    step("addiex");
  endtask

  task automatic ph_addiwb();
    rnd_in(); base(1'b0); rdst(2'd0); m2r(2'd0); e.RegWrite = 1'b1;
    step("addiwb");
  endtask

  task automatic ph_jump();
    rnd_in(); base(1'b0); pcs(2'd2); e.PCWrite = 1'b1; e.PCEn = 1'b1;
    step("jump");
  endtask

  task automatic ph_jal();
    rnd_in(); base(1'b0); rdst(2'd2); m2r(2'd2); pcs(2'd2);
    e.RegWrite = 1'b1; e.PCWrite = 1'b1; e.PCEn = 1'b1;
    step("jal");
  endtask

  task automatic ph_trap();
    rnd_in(); base(1'b1);
    step("trap");
  endtask

  // Leaves rst low at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b1;
    e = '0; m = '1; m.illegal = 1'b0;
    settle_check("rst_cycle", 1'b0);
    @(negedge clk);
    exp_cnt = '0;
    e = '0; m = '1;
    settle_check("rst_state", 1'b1);
    rst = 1'b0;
  endtask

  logic [5:0] fn_tab [7];
  logic [3:0] code_tab [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    fn_tab   = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
    code_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT};
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      OpCode = OP_RTYPE; Funct = fn_tab[i];
      ph_fetch(1'b1); ph_decode(); ph_exec(code_tab[i], 1'b1); ph_aluwb();
      exp_cnt++;
    end

    OpCode = OP_LW;
    ph_fetch(1'b0); ph_fetch(1'b1); ph_decode(); ph_memadr();
    ph_memrd(1'b0); ph_memrd(1'b0); ph_memrd(1'b0); ph_memrd(1'b1); ph_memwb();
    exp_cnt++;

    for (int i = 0; i < 4; i++) begin
      OpCode = i[1] ? OP_BNE : OP_BEQ;
      ph_fetch(1'b1); ph_decode(); ph_branch(~i[1], ~i[0]);
      exp_cnt++;
    end

    OpCode = OP_ADDI;
    ph_fetch(1'b1); ph_decode(); ph_addiex(); ph_addiwb();
    exp_cnt++;

    OpCode = OP_J;
    ph_fetch(1'b1); ph_decode(); ph_jump();
    exp_cnt++;

    OpCode = OP_SW;
    ph_fetch(1'b1); ph_decode(); ph_memadr(); ph_memwr(1'b0); ph_memwr(1'b1);
    exp_cnt++;

    OpCode = OP_JAL;
    ph_fetch(1'b1); ph_decode();
`ifdef MIPS_CTRL_JAL_EN
    ph_jal();
    exp_cnt++;
`else
    ph_trap(); ph_trap();
    do_reset();
`endif

    OpCode = OP_SW;
    ph_fetch(1'b1); ph_decode(); ph_memadr(); ph_memwr(1'b0);
    do_reset();
    ph_fetch(1'b0);

    OpCode = 6'h3F;
    ph_fetch(1'b1); ph_decode();
    for (int i = 0; i < 20; i++) ph_trap();
    do_reset();

    OpCode = OP_RTYPE; Funct = 6'h00;
    ph_fetch(1'b1); ph_decode(); ph_exec(ALU_ADD, 1'b0);
    ph_trap(); ph_trap(); ph_trap();
    do_reset();
    ph_fetch(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
